// File: rtl/ifmap_radr_gen_pd.sv
// Read-address generator for the ifmap double buffer: walks the tiled-convolution
// loop nest with stride, dilation and zero-padding, flagging the final address.
module ifmap_radr_gen_pd #(
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int CFG_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       adr_en,
  output logic [BANK_ADDR_WIDTH-1:0] adr,
  output logic                       adr_pad,
  output logic                       last,
  output logic                       done,
  input  logic                       config_en,
  input  logic [CFG_WIDTH*11-1:0]    config_data
);

  localparam int CW = 2*CFG_WIDTH + 2;
  localparam int AW = BANK_ADDR_WIDTH;

  // Packed so that config_data loads directly; index 10 is the MSB field.
  localparam int F_OX0 = 10, F_OY0 = 9, F_FX = 8, F_FY = 7, F_STR = 6, F_DIL = 5;
  localparam int F_PAD = 4, F_IX0 = 3, F_IY0 = 2, F_IC1 = 1, F_OC1 = 0;

  localparam int L_OX0 = 0, L_OY0 = 1, L_FX = 2, L_FY = 3, L_IC1 = 4, L_OC1 = 5;

  logic [10:0][CFG_WIDTH-1:0] cfg_q;
  logic [5:0][CFG_WIDTH-1:0]  cnt_q, cnt_d, cnt_max;
  logic [5:0]                 at_max;
  logic                       done_q;

  logic [CFG_WIDTH-1:0] str_e, dil_e, ix0_e, iy0_e;
  logic [CW-1:0]        iy, ix;

  function automatic logic [CFG_WIDTH-1:0] eff(input logic [CFG_WIDTH-1:0] v);
    return (v == '0) ? CFG_WIDTH'(1) : v;
  endfunction

  always_comb begin
    str_e = eff(cfg_q[F_STR]);
    dil_e = eff(cfg_q[F_DIL]);
    ix0_e = eff(cfg_q[F_IX0]);
    iy0_e = eff(cfg_q[F_IY0]);
    cnt_max[L_OX0] = eff(cfg_q[F_OX0]) - CFG_WIDTH'(1);
    cnt_max[L_OY0] = eff(cfg_q[F_OY0]) - CFG_WIDTH'(1);
    cnt_max[L_FX]  = eff(cfg_q[F_FX])  - CFG_WIDTH'(1);
    cnt_max[L_FY]  = eff(cfg_q[F_FY])  - CFG_WIDTH'(1);
    cnt_max[L_IC1] = eff(cfg_q[F_IC1]) - CFG_WIDTH'(1);
    cnt_max[L_OC1] = eff(cfg_q[F_OC1]) - CFG_WIDTH'(1);
  end

  // Ripple-carry odometer, innermost level first; a step at last wraps everything.
  always_comb begin
    logic carry;
    carry  = 1'b1;
    cnt_d  = cnt_q;
    at_max = '0;
    for (int unsigned l = 0; l < 6; l++) begin
      at_max[l] = (cnt_q[l] == cnt_max[l]);
      if (carry) begin
        if (at_max[l]) begin
          cnt_d[l] = '0;
        end else begin
          cnt_d[l] = cnt_q[l] + CFG_WIDTH'(1);
          carry    = 1'b0;
        end
      end
    end
  end

  assign last = &at_max;

  // Products are non-negative and fit in CW-1 bits, so the MSB is the sign after -PAD.
  always_comb begin
    iy = CW'(cnt_q[L_OY0]) * CW'(str_e) + CW'(cnt_q[L_FY]) * CW'(dil_e) - CW'(cfg_q[F_PAD]);
    ix = CW'(cnt_q[L_OX0]) * CW'(str_e) + CW'(cnt_q[L_FX]) * CW'(dil_e) - CW'(cfg_q[F_PAD]);
    adr_pad = iy[CW-1] | ix[CW-1] | (iy >= CW'(iy0_e)) | (ix >= CW'(ix0_e));
    adr = '0;
    if (!adr_pad) begin
      adr = (AW'(cnt_q[L_IC1]) * AW'(iy0_e) + AW'(iy)) * AW'(ix0_e) + AW'(ix);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (config_en) begin
      cfg_q  <= config_data;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (adr_en) begin
      cnt_q  <= cnt_d;
      done_q <= last;
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_ifmap_radr_gen_pd.sv
// Directed bench for ifmap_radr_gen_pd: hand-computed address sequences for
// raster, overlapping filter, stride/dilation, padding, channel tiling and control.
module tb_ifmap_radr_gen_pd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adr_en = 1'b0;
  logic        config_en = 1'b0;
  logic [87:0] config_data = '0;
  logic [7:0]  adr;
  logic        adr_pad, last, done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifmap_radr_gen_pd #(.BANK_ADDR_WIDTH(8), .CFG_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adr_en     (adr_en),
    .adr        (adr),
    .adr_pad    (adr_pad),
    .last       (last),
    .done       (done),
    .config_en  (config_en),
    .config_data(config_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic configure(input int ox0, input int oy0, input int fx, input int fy,
                           input int st, input int dl, input int pd, input int ix0,
                           input int iy0, input int ic1, input int oc1, input logic with_step);
    config_data = {8'(ox0), 8'(oy0), 8'(fx), 8'(fy), 8'(st), 8'(dl), 8'(pd),
                   8'(ix0), 8'(iy0), 8'(ic1), 8'(oc1)};
    config_en = 1'b1;
    adr_en    = with_step;
    @(negedge clk);
    config_en = 1'b0;
    adr_en    = 1'b0;
  endtask

  int e8[8]       = '{0, 1, 4, 5, 1, 2, 5, 6};
  int e4[4]       = '{0, 2, 2, 4};
  int pad_adr[12] = '{0, 0, 0, 0,  0, 1, 2, 3,  3, 0, 0, 0};
  int pad_flg[12] = '{1, 1, 1, 0,  0, 0, 0, 0,  0, 1, 1, 1};

  initial begin
    // Reset state
    #7;
    chk("rst_adr", adr, 0);
    chk("rst_pad", adr_pad, 0);
    chk("rst_last", last, 1);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_adr", adr, 0);
    chk("rel_last", last, 1);

    // Basic raster
    configure(2, 2, 1, 1, 1, 1, 0, 2, 2, 1, 1, 1'b0);
    adr_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("raster_adr", adr, k);
      chk("raster_last", last, k == 3);
      chk("raster_done", done, 0);
      @(negedge clk);
    end
    chk("raster_done_pulse", done, 1);
    chk("raster_wrap_adr", adr, 0);
    adr_en = 1'b0;
    @(negedge clk);
    chk("raster_done_clear", done, 0);

    // Overlapping 3x3 filter
    configure(2, 2, 3, 3, 1, 1, 0, 4, 4, 1, 1, 1'b0);
    adr_en = 1'b1;
    for (int k = 0; k < 36; k++) begin
      if (k < 8) chk("f3_adr", adr, e8[k]);
      if (k == 35) chk("f3_final_adr", adr, 15);
      chk("f3_last", last, k == 35);
      @(negedge clk);
    end
    chk("f3_wrap_adr", adr, 0);
    chk("f3_done", done, 1);
    adr_en = 1'b0;
    @(negedge clk);

    // Stride and dilation
    configure(2, 1, 2, 1, 2, 2, 0, 5, 1, 1, 1, 1'b0);
    adr_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("sd_adr", adr, e4[k]);
      chk("sd_last", last, k == 3);
      @(negedge clk);
    end
    chk("sd_done", done, 1);
    adr_en = 1'b0;
    @(negedge clk);

    // Padding: windows fy=fx=0, fy=fx=1, fy=fx=2
    configure(2, 2, 3, 3, 1, 1, 1, 2, 2, 1, 1, 1'b0);
    adr_en = 1'b1;
    for (int k = 0; k < 36; k++) begin
      int w;
      w = (k < 4) ? k : (k >= 16 && k < 20) ? k - 12 : (k >= 32) ? k - 24 : -1;
      if (w >= 0) begin
        chk("pad_flag", adr_pad, pad_flg[w]);
        chk("pad_adr", adr, pad_adr[w]);
      end
      @(negedge clk);
    end
    chk("pad_done", done, 1);
    adr_en = 1'b0;
    @(negedge clk);

    // Channel tiling
    configure(2, 2, 1, 1, 1, 1, 0, 2, 2, 2, 2, 1'b0);
    adr_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("ch_adr", adr, k % 8);
      chk("ch_last", last, k == 15);
      chk("ch_done", done, 0);
      @(negedge clk);
    end
    chk("ch_done_pulse", done, 1);
    chk("ch_wrap_adr", adr, 0);
    adr_en = 1'b0;
    @(negedge clk);
    chk("ch_done_clear", done, 0);

    // Hold with adr_en low
    configure(2, 2, 1, 1, 1, 1, 0, 2, 2, 1, 1, 1'b0);
    adr_en = 1'b1;
    repeat (2) @(negedge clk);
    adr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_adr", adr, 2);
      chk("hold_last", last, 0);
      chk("hold_done", done, 0);
    end
    adr_en = 1'b1;
    @(negedge clk);
    chk("resume_adr", adr, 3);
    chk("resume_last", last, 1);
    adr_en = 1'b0;

    // config_en wins over adr_en
    configure(2, 2, 3, 3, 1, 1, 0, 4, 4, 1, 1, 1'b1);
    chk("cfgwin_adr", adr, 0);
    chk("cfgwin_last", last, 0);
    chk("cfgwin_done", done, 0);
    adr_en = 1'b1;
    @(negedge clk);
    chk("cfgwin_next_adr", adr, 1);
    adr_en = 1'b0;

    // Async reset mid-sequence, nonzero address
    configure(2, 2, 1, 1, 1, 1, 0, 2, 2, 1, 1, 1'b0);
    adr_en = 1'b1;
    repeat (2) @(negedge clk);
    adr_en = 1'b0;
    chk("pre_rst_adr", adr, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_adr", adr, 0);
    chk("async_rst_last", last, 1);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Async reset while done is high
    configure(2, 2, 1, 1, 1, 1, 0, 2, 2, 1, 1, 1'b0);
    adr_en = 1'b1;
    repeat (4) @(negedge clk);
    adr_en = 1'b0;
    chk("pre_rst_done", done, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_done", done, 0);
    chk("async_rst_pad", adr_pad, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_adr", adr, 0);
    chk("post_rst_last", last, 1);
    chk("post_rst_done", done, 0);

    // After reset every count reads as 1: each step is a full sequence
    adr_en = 1'b1;
    @(negedge clk);
    chk("ones_done1", done, 1);
    chk("ones_adr", adr, 0);
    chk("ones_last", last, 1);
    @(negedge clk);
    chk("ones_done2", done, 1);
    adr_en = 1'b0;
    @(negedge clk);
    chk("ones_done_clear", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
